// File: rtl/trace_logger.sv
// Diagnostic trace capture: a circular RAM keeps PRE_TRIG samples of history plus a
// fixed post-trigger window, then streams the capture out oldest-first over valid/ready.
module trace_logger #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 9,
    parameter int PRE_TRIG   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic [1:0]            trig_mode,
    input  logic                  trig,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_start,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic [2:0]            state,
    output logic [ADDR_WIDTH:0]   word_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   POST_V = (ADDR_WIDTH+1)'(DEPTH - PRE_TRIG);
    localparam logic [ADDR_WIDTH-1:0] PRE_V  = ADDR_WIDTH'(PRE_TRIG);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        DONE    = 3'd3,
        READ    = 3'd4
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH-1:0] start_ptr;
    logic [ADDR_WIDTH-1:0] pre_cnt;
    logic [ADDR_WIDTH:0]   post_cnt;
    logic [ADDR_WIDTH:0]   rd_cnt;
    logic [ADDR_WIDTH:0]   total;
    logic                  trig_prev;
    logic                  first_armed;
    logic                  trig_evt;
    logic                  restart;
    logic                  ram_we;
    logic                  finish;
    logic                  fire;

    // Immediate mode fires on the first ARMED cycle, before any history is kept.
    always_comb begin
        trig_evt = 1'b0;
        case (trig_mode)
            2'b01:   trig_evt = trig & ~trig_prev;
            2'b10:   trig_evt = first_armed;
            default: trig_evt = trig;
        endcase
    end

    assign restart = arm && (state_q != READ);
    assign ram_we  = wr_en && !arm && (state_q == ARMED || state_q == CAPTURE);
    assign finish  = ram_we &&
                     ((state_q == CAPTURE && (post_cnt + 1'b1) == POST_V) ||
                      (state_q == ARMED && trig_evt && POST_V == (ADDR_WIDTH+1)'(1)));
    assign total   = {1'b0, pre_cnt} + POST_V;
    assign fire    = rd_valid && rd_ready;
    assign state   = state_q;

    always_ff @(posedge clk) begin
        if (ram_we) ram[wptr] <= data_in;
    end

    // Entering DONE is applied after the case so it overrides the CAPTURE hand-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wptr        <= '0;
            rptr        <= '0;
            start_ptr   <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            rd_cnt      <= '0;
            word_count  <= '0;
            trig_prev   <= 1'b0;
            first_armed <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            rd_last     <= 1'b0;
        end else begin
            trig_prev <= trig;
            if (restart) begin
                state_q     <= ARMED;
                wptr        <= '0;
                pre_cnt     <= '0;
                post_cnt    <= '0;
                word_count  <= '0;
                first_armed <= 1'b1;
            end else begin
                first_armed <= 1'b0;
                case (state_q)
                    ARMED: begin
                        if (ram_we) wptr <= wptr + 1'b1;
                        if (trig_evt) begin
                            state_q  <= CAPTURE;
                            post_cnt <= {{ADDR_WIDTH{1'b0}}, wr_en};
                        end else if (wr_en && pre_cnt != PRE_V) begin
                            pre_cnt <= pre_cnt + 1'b1;
                        end
                    end
                    CAPTURE: begin
                        if (ram_we) begin
                            wptr     <= wptr + 1'b1;
                            post_cnt <= post_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        if (rd_start) begin
                            state_q <= READ;
                            rptr    <= start_ptr;
                            rd_cnt  <= '0;
                        end
                    end
                    READ: begin
                        if (fire && rd_last) begin
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                            state_q  <= IDLE;
                        end else if (!rd_valid || fire) begin
                            rd_data  <= ram[rptr];
                            rptr     <= rptr + 1'b1;
                            rd_valid <= 1'b1;
                            rd_cnt   <= rd_cnt + 1'b1;
                            rd_last  <= ((rd_cnt + 1'b1) == word_count);
                        end
                    end
                    default: ;
                endcase
                if (finish) begin
                    state_q    <= DONE;
                    word_count <= total;
                    start_ptr  <= wptr + 1'b1 - total[ADDR_WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_trace_logger.sv
// Directed bench for trace_logger on a 16-deep RAM with 4 samples of pre-trigger history.
module tb_trace_logger;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int PT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic [1:0]    trig_mode = 2'b00;
    logic          trig = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rd_start = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic          rd_last;
    logic [2:0]    state;
    logic [AW:0]   word_count;

    int compare_count = 0;
    int fail_count    = 0;

    trace_logger #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRE_TRIG(PT)) dut (
        .clk(clk), .rst(rst), .arm(arm), .trig_mode(trig_mode), .trig(trig),
        .wr_en(wr_en), .data_in(data_in), .rd_start(rd_start), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .state(state), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compare_count++;
        if (observed != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Inputs are presented 1 time unit after an edge and consumed by the next edge.
    task automatic applyStimulus(input logic a, input logic rs, input logic w,
                                 input logic [DW-1:0] d, input logic t);
        arm      = a;
        rd_start = rs;
        wr_en    = w;
        data_in  = d;
        trig     = t;
        @(posedge clk);
        #1;
        arm      = 1'b0;
        rd_start = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic readCapture(input int first, input int n, input bit rand_ready);
        int          idx;
        int          first_valid;
        bit          hold_pending;
        bit          rdy;
        logic [DW-1:0] hold_data;
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("rd_enter_state", state, 4);
        checkOutput("rd_prefetch_valid", rd_valid, 0);
        idx          = 0;
        first_valid  = -1;
        hold_pending = 1'b0;
        hold_data    = '0;
        for (int cyc = 0; cyc < 300 && idx < n; cyc++) begin
            rdy      = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_ready = rdy;
            if (hold_pending) begin
                checkOutput("stall_valid", rd_valid, 1);
                checkOutput("stall_data", rd_data, hold_data);
                hold_pending = 1'b0;
            end
            if (rd_valid) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    checkOutput("rd_latency", cyc, 1);
                end
                if (rdy) begin
                    checkOutput("rd_data", rd_data, (first + idx) & 8'hFF);
                    checkOutput("rd_last", rd_last, (idx == n - 1) ? 1 : 0);
                    idx++;
                end else begin
                    hold_data    = rd_data;
                    hold_pending = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        rd_ready = 1'b0;
        checkOutput("rd_word_total", idx, n);
        checkOutput("rd_end_valid", rd_valid, 0);
        checkOutput("rd_end_state", state, 0);
        checkOutput("rd_keep_count", word_count, n);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_state", state, 0);
        checkOutput("rst_valid", rd_valid, 0);
        checkOutput("rst_last", rd_last, 0);
        checkOutput("rst_data", rd_data, 0);
        checkOutput("rst_count", word_count, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
        checkOutput("idle_ignores_inputs", state, 0);

        // Level trigger with full history
        trig_mode = 2'b00;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("s1_armed", state, 1);
        for (int d = 0; d <= 21; d++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(d), d == 10);
            if (d == 9)  checkOutput("s1_pre_armed", state, 1);
            if (d == 10) checkOutput("s1_capture", state, 2);
            if (d == 20) checkOutput("s1_not_done_early", state, 2);
        end
        checkOutput("s1_done", state, 3);
        checkOutput("s1_count", word_count, 16);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0);
        checkOutput("s1_done_holds", state, 3);
        readCapture(6, 16, 1'b0);

        // Short history, readout under random backpressure
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int d = 0; d <= 13; d++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(d), d == 2);
        checkOutput("s2_done", state, 3);
        checkOutput("s2_count", word_count, 14);
        readCapture(0, 14, 1'b1);

        // Rising-edge trigger, trig already high at arm
        trig_mode = 2'b01;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        for (int d = 0; d <= 18; d++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(d), d != 6);
            if (d == 5) checkOutput("s3_held_no_trig", state, 1);
            if (d == 7) checkOutput("s3_edge_trig", state, 2);
        end
        checkOutput("s3_done", state, 3);
        checkOutput("s3_count", word_count, 16);
        readCapture(3, 16, 1'b1);

        // Immediate mode ignores history
        trig_mode = 2'b10;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int d = 0; d <= 11; d++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(d), 1'b0);
            if (d == 10) checkOutput("s4_capture", state, 2);
        end
        checkOutput("s4_done", state, 3);
        checkOutput("s4_count", word_count, 12);
        readCapture(0, 12, 1'b0);

        // arm beats rd_start in DONE; arm ignored in READ; async reset mid-read
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int d = 0; d <= 11; d++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(d), 1'b0);
        checkOutput("s5_done", state, 3);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("s5_arm_wins", state, 1);
        checkOutput("s5_arm_clears_count", word_count, 0);
        for (int d = 20; d <= 31; d++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(d), 1'b0);
        checkOutput("s5_done_again", state, 3);
        checkOutput("s5_count", word_count, 12);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("s5_arm_in_read", state, 4);
        checkOutput("s5_first_word", rd_data, 20);
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("s5_second_word", rd_data, 21);
        rst = 1'b1;
        #1;
        checkOutput("s5_rst_valid", rd_valid, 0);
        checkOutput("s5_rst_state", state, 0);
        checkOutput("s5_rst_count", word_count, 0);
        rd_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Restart from CAPTURE, then a full fresh capture
        trig_mode = 2'b00;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int d = 0; d <= 4; d++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(d + 60), d == 3);
        checkOutput("s6_capture", state, 2);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
        checkOutput("s6_restart_state", state, 1);
        checkOutput("s6_restart_count", word_count, 0);
        for (int d = 100; d <= 116; d++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(d), d == 105);
        checkOutput("s6_done", state, 3);
        checkOutput("s6_count", word_count, 16);
        readCapture(101, 16, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end
endmodule
